// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion controller.
// Holds the FSM state encoding, the default resolution and sample length,
// and the width helper used to size the internal counters.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2
    } sar_state_t;

    localparam int SAR_DEFAULT_WIDTH         = 8;
    localparam int SAR_DEFAULT_SAMPLE_CYCLES = 2;

    // Counter width for a count range of n, never narrower than one bit
    function automatic int cntWidth(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sar_bit_cell.sv
// One bit of the SAR trial/result register.
// Clear wins over set, set wins over load, otherwise the bit holds.
// Set marks this bit as the current trial; load replaces the trial with
// the comparator decision once the bit is resolved.
module sar_bit_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_set,
    input  logic i_load,
    input  logic i_comp,
    output logic o_bit
);

    logic r_bit;

    // Single code flip-flop with prioritised clear/set/load controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= 1'b0;
        end else if (i_clr) begin
            r_bit <= 1'b0;
        end else if (i_set) begin
            r_bit <= 1'b1;
        end else if (i_load) begin
            r_bit <= i_comp;
        end
    end

    assign o_bit = r_bit;

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: sample phase followed by a WIDTH-bit
// binary search steered by the comparator. dac_code is the trial code for
// the capacitive DAC; result/valid publish each finished conversion.
// Optional feature macro: SAR_CONT_EN adds the cont input, which chains
// conversions back-to-back without returning to IDLE.
module sar_logic
    import sar_pkg::*;
#(
    parameter int WIDTH         = SAR_DEFAULT_WIDTH,
    parameter int SAMPLE_CYCLES = SAR_DEFAULT_SAMPLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             comp,
`ifdef SAR_CONT_EN
    input  logic             cont,
`endif
    output logic             sample,
    output logic             busy,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int PTR_W = cntWidth(WIDTH);
    localparam int CNT_W = cntWidth(SAMPLE_CYCLES);
    localparam logic [PTR_W-1:0] PTR_MSB  = PTR_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

    sar_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_ptr;
    logic             r_sample;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;

    logic             w_cont;
    logic             w_lastSample;
    logic             w_lastBit;
    logic [PTR_W-1:0] w_ptrNext;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_code;

`ifdef SAR_CONT_EN
    assign w_cont = cont;
`else
    assign w_cont = 1'b0;
`endif

    assign w_lastSample = (r_state == SAMPLE) && (r_cnt == CNT_LAST);
    assign w_lastBit    = (r_state == CONVERT) && (r_ptr == '0);
    assign w_ptrNext    = r_ptr - 1'b1;

    // Per-bit controls: MSB trial on leaving SAMPLE, then load the bit under
    // the pointer while arming the next lower bit as the new trial
    always_comb begin
        w_set  = '0;
        w_load = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_lastSample && (i == WIDTH - 1)) begin
                w_set[i] = 1'b1;
            end
            if ((r_state == CONVERT) && !w_lastBit && (w_ptrNext == PTR_W'(i))) begin
                w_set[i] = 1'b1;
            end
            if ((r_state == CONVERT) && (r_ptr == PTR_W'(i))) begin
                w_load[i] = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            sar_bit_cell u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_clr  (w_lastBit),
                .i_set  (w_set[g]),
                .i_load (w_load[g]),
                .i_comp (comp),
                .o_bit  (w_code[g])
            );
        end
    endgenerate

    // Conversion sequencer with sample counter, bit pointer and result strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SAMPLE;
                        r_busy   <= 1'b1;
                        r_sample <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                SAMPLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= CONVERT;
                        r_sample <= 1'b0;
                        r_ptr    <= PTR_MSB;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (r_ptr == '0) begin
                        r_result <= {w_code[WIDTH-1:1], comp};
                        r_valid  <= 1'b1;
                        if (w_cont) begin
                            r_state  <= SAMPLE;
                            r_sample <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_ptr <= w_ptrNext;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sample   = r_sample;
    assign busy     = r_busy;
    assign dac_code = w_code;
    assign result   = r_result;
    assign valid    = r_valid;

endmodule
